rk4_trace_buffer: RTL and testbench

Captures every intermediate Y value produced by the RK4 loop into a small on-chip buffer. After the run, the user steps through the stored results with two board buttons. It sits downstream of the RK4 datapath, fed by the per-iteration Y strobe and the run-complete indication from the control FSM. Its selected word drives the existing hex-nibble split and seven-segment path in place of the single final-value register.

---
 rtl/rk4_trace_buffer.sv | 190 +++++++++++++++++++
 tb/tb_rk4_trace_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rk4_trace_buffer.sv
// Trace buffer for intermediate RK4 Y values with debounced NEXT/PREV browsing.
// Optional ring-buffer capture is enabled by defining RK4_TRACE_RING_EN.
module rk4_trace_buffer #(
   parameter int unsigned n         = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AW        = 4,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [n-1:0]  Y_IN,
   input  logic          Y_VALID,
   input  logic          DONE,
   input  logic          BTN_NEXT,
   input  logic          BTN_PREV,
   output logic [n-1:0]  DISP_WORD,
   output logic [AW-1:0] DISP_IDX,
   output logic [AW:0]   COUNT,
   output logic          EMPTY,
   output logic          FULL,
   output logic          OVERFLOW
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DbLast = CW'(DB_CYCLES - 1);
   localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StCapture, StBrowse} state_e;

   state_e        state_q, state_d;
   logic          start_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [n-1:0]  word_q, word_d;
   logic [n-1:0]  mem_q [DEPTH];
   logic          mem_we;
   logic [AW-1:0] phys_idx;
`ifdef RK4_TRACE_RING_EN
   logic [AW-1:0] oldest_q, oldest_d;
`endif

   // Button path: bit 0 = NEXT, bit 1 = PREV
   logic [1:0]    sync1_q, sync2_q;
   logic [1:0]    btn_lvl_q, btn_lvl_d;
   logic [1:0]    btn_prev_q;
   logic [CW-1:0] db_cnt_q [2];
   logic [CW-1:0] db_cnt_d [2];
   logic [1:0]    btn_pulse;
   logic          start_rise, empty, full, step_next, step_prev;

   assign start_rise = START & ~start_q;
   assign empty      = (count_q == '0);
   assign full       = (count_q == CountFull);
   assign btn_pulse  = btn_lvl_q & ~btn_prev_q;
   assign step_next  = (state_q == StBrowse) && btn_pulse[0] && !btn_pulse[1];
   assign step_prev  = (state_q == StBrowse) && btn_pulse[1] && !btn_pulse[0];

`ifdef RK4_TRACE_RING_EN
   assign phys_idx = oldest_q + idx_q;
`else
   assign phys_idx = idx_q;
`endif

   // Accepted level flips only after DB_CYCLES consecutive samples disagree with it
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         db_cnt_d[b]  = '0;
         btn_lvl_d[b] = btn_lvl_q[b];
         if (sync2_q[b] != btn_lvl_q[b]) begin
            if (db_cnt_q[b] == DbLast) btn_lvl_d[b] = sync2_q[b];
            else                       db_cnt_d[b]  = db_cnt_q[b] + 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      idx_d    = idx_q;
      mem_we   = 1'b0;
`ifdef RK4_TRACE_RING_EN
      oldest_d = oldest_q;
`endif
      if (start_rise) begin
         state_d  = StCapture;
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         idx_d    = '0;
`ifdef RK4_TRACE_RING_EN
         oldest_d = '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: ;
            StCapture: begin
               if (Y_VALID) begin
`ifdef RK4_TRACE_RING_EN
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (full) begin
                     oldest_d = oldest_q + 1'b1;
                     ovf_d    = 1'b1;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
`else
                  if (!full) begin
                     mem_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     count_d  = count_q + 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
`endif
               end
               if (DONE) begin
                  state_d = StBrowse;
                  idx_d   = '0;
               end
            end
            StBrowse: begin
               if (empty) begin
                  idx_d = '0;
               end else if (step_next) begin
                  idx_d = (idx_q == count_q[AW-1:0] - 1'b1) ? '0 : idx_q + 1'b1;
               end else if (step_prev) begin
                  idx_d = (idx_q == '0) ? count_q[AW-1:0] - 1'b1 : idx_q - 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      word_d = empty ? '0 : mem_q[phys_idx];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         start_q    <= 1'b0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         idx_q      <= '0;
         word_q     <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         btn_lvl_q  <= '0;
         btn_prev_q <= '0;
         db_cnt_q   <= '{default: '0};
`ifdef RK4_TRACE_RING_EN
         oldest_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         start_q    <= START;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         sync1_q    <= {BTN_PREV, BTN_NEXT};
         sync2_q    <= sync1_q;
         btn_lvl_q  <= btn_lvl_d;
         btn_prev_q <= btn_lvl_q;
         db_cnt_q   <= db_cnt_d;
`ifdef RK4_TRACE_RING_EN
         oldest_q   <= oldest_d;
`endif
      end
   end

   // Storage has no reset; contents are meaningless until written
   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[wr_ptr_q] <= Y_IN;
   end

   assign DISP_WORD = word_q;
   assign DISP_IDX  = idx_q;
   assign COUNT     = count_q;
   assign EMPTY     = empty;
   assign FULL      = full;
   assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_rk4_trace_buffer.sv
// Directed bench for rk4_trace_buffer; expectations follow RK4_TRACE_RING_EN when defined.
module tb_rk4_trace_buffer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [31:0] Y_IN = '0;
   logic        Y_VALID = 1'b0;
   logic        DONE = 1'b0;
   logic        BTN_NEXT = 1'b0;
   logic        BTN_PREV = 1'b0;
   logic [31:0] DISP_WORD;
   logic [3:0]  DISP_IDX;
   logic [4:0]  COUNT;
   logic        EMPTY, FULL, OVERFLOW;

   int n_checks = 0;
   int n_bad    = 0;

   rk4_trace_buffer dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .Y_IN      (Y_IN),
      .Y_VALID   (Y_VALID),
      .DONE      (DONE),
      .BTN_NEXT  (BTN_NEXT),
      .BTN_PREV  (BTN_PREV),
      .DISP_WORD (DISP_WORD),
      .DISP_IDX  (DISP_IDX),
      .COUNT     (COUNT),
      .EMPTY     (EMPTY),
      .FULL      (FULL),
      .OVERFLOW  (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int cycles = 1);
      for (int i = 0; i < cycles; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic pulse_start();
      START = 1'b1;
      tick();
      START = 1'b0;
      tick();
   endtask

   task automatic write_y(input logic [31:0] val);
      Y_IN    = val;
      Y_VALID = 1'b1;
      tick();
      Y_VALID = 1'b0;
   endtask

   task automatic press(input logic nxt, input logic prv);
      BTN_NEXT = nxt;
      BTN_PREV = prv;
      tick(10);
      BTN_NEXT = 1'b0;
      BTN_PREV = 1'b0;
      tick(10);
   endtask

   logic [31:0] exp_word;
   logic [3:0]  exp_idx;

   initial begin
      tick(2);
      check_eq("rst_word", DISP_WORD, 32'h0);
      check_eq("rst_idx", {28'h0, DISP_IDX}, 32'h0);
      check_eq("rst_count", {27'h0, COUNT}, 32'h0);
      check_eq("rst_empty", {31'h0, EMPTY}, 32'h1);
      check_eq("rst_full", {31'h0, FULL}, 32'h0);
      check_eq("rst_ovf", {31'h0, OVERFLOW}, 32'h0);
      RST = 1'b0;
      tick();

      // Y_VALID in IDLE is ignored
      write_y(32'hDEAD_BEEF);
      check_eq("idle_ignore", {27'h0, COUNT}, 32'h0);

      pulse_start();
      for (int k = 0; k < 10; k++) begin
         write_y(32'h0001_0000 + k * 32'h1000);
         if (k == 0) check_eq("first_write_count", {27'h0, COUNT}, 32'h1);
      end
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      tick();
      check_eq("cap10_count", {27'h0, COUNT}, 32'd10);
      check_eq("cap10_full", {31'h0, FULL}, 32'h0);
      check_eq("cap10_ovf", {31'h0, OVERFLOW}, 32'h0);
      check_eq("browse_idx0", {28'h0, DISP_IDX}, 32'h0);
      check_eq("browse_word0", DISP_WORD, 32'h0001_0000);

      for (int i = 0; i < 10; i++) begin
         press(1'b1, 1'b0);
         exp_idx  = 4'((i + 1) % 10);
         exp_word = 32'h0001_0000 + 32'(exp_idx) * 32'h1000;
         check_eq($sformatf("next_idx_%0d", i), {28'h0, DISP_IDX}, {28'h0, exp_idx});
         check_eq($sformatf("next_word_%0d", i), DISP_WORD, exp_word);
      end
      press(1'b0, 1'b1);
      check_eq("prev_wrap_idx", {28'h0, DISP_IDX}, 32'd9);
      check_eq("prev_wrap_word", DISP_WORD, 32'h0001_9000);

      // Bouncing NEXT never settles long enough to be accepted
      BTN_NEXT = 1'b1; tick();
      BTN_NEXT = 1'b0; tick();
      BTN_NEXT = 1'b1; tick();
      BTN_NEXT = 1'b0; tick(12);
      check_eq("bounce_idx", {28'h0, DISP_IDX}, 32'd9);

      press(1'b1, 1'b1);
      check_eq("both_idx", {28'h0, DISP_IDX}, 32'd9);

      pulse_start();
      check_eq("restart_count", {27'h0, COUNT}, 32'h0);
      check_eq("restart_empty", {31'h0, EMPTY}, 32'h1);
      check_eq("restart_word", DISP_WORD, 32'h0);
      check_eq("restart_idx", {28'h0, DISP_IDX}, 32'h0);

      for (int k = 0; k < 20; k++) write_y(32'(k));
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      tick();
      check_eq("ovf_count", {27'h0, COUNT}, 32'd16);
      check_eq("ovf_full", {31'h0, FULL}, 32'h1);
      check_eq("ovf_flag", {31'h0, OVERFLOW}, 32'h1);
`ifdef RK4_TRACE_RING_EN
      check_eq("ovf_word_idx0", DISP_WORD, 32'd4);
`else
      check_eq("ovf_word_idx0", DISP_WORD, 32'd0);
`endif
      press(1'b0, 1'b1);
      check_eq("ovf_idx15", {28'h0, DISP_IDX}, 32'd15);
`ifdef RK4_TRACE_RING_EN
      check_eq("ovf_word_idx15", DISP_WORD, 32'd19);
`else
      check_eq("ovf_word_idx15", DISP_WORD, 32'd15);
`endif
      press(1'b1, 1'b0);
      check_eq("ovf_next_wrap", {28'h0, DISP_IDX}, 32'd0);

      // Asynchronous reset mid-capture
      pulse_start();
      for (int k = 0; k < 5; k++) write_y(32'h100 + 32'(k));
      check_eq("mid_count", {27'h0, COUNT}, 32'd5);
      #2;
      RST = 1'b1;
      #1;
      check_eq("arst_word", DISP_WORD, 32'h0);
      check_eq("arst_count", {27'h0, COUNT}, 32'h0);
      check_eq("arst_empty", {31'h0, EMPTY}, 32'h1);
      check_eq("arst_ovf", {31'h0, OVERFLOW}, 32'h0);
      tick();
      RST = 1'b0;
      tick();
      write_y(32'h55);
      check_eq("arst_idle", {27'h0, COUNT}, 32'h0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
